// File: rtl/lockstep_fifo.sv
// rtl/lockstep_fifo.sv - Redundant lockstep FIFO: LANES identical circular buffers with cross-lane disagreement detection.
module lockstep_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_read_ctrl,
    input  logic                       in_write_ctrl,
    input  logic [WIDTH-1:0]           in_write_data,
    input  logic                       in_inject_en,
    input  logic [LANES-1:0]           in_inject_lane,
    input  logic [WIDTH-1:0]           in_inject_mask,
    input  logic                       in_clear_err,
    output logic [WIDTH-1:0]           out_read_data,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       out_is_full,
    output logic                       out_is_empty,
    output logic                       out_mismatch,
    output logic [LANES-1:0]           out_mismatch_lane
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [LANES-1:0][WIDTH-1:0] lane_rdata;
    logic [LANES-1:0][CW-1:0]    lane_cnt;
    logic [LANES-1:0]            lane_full;
    logic [LANES-1:0]            lane_empty;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] rdata;
        logic             full;
        logic             empty;
        logic             pop_ok;
        logic             push_ok;
        logic [WIDTH-1:0] wdata;

        assign full    = (cnt == FULL_CNT);
        assign empty   = (cnt == '0);
        assign pop_ok  = in_read_ctrl && !empty;
        // A pop in the same cycle frees a slot, so a full lane may still accept a push.
        assign push_ok = in_write_ctrl && (!full || pop_ok);
        assign wdata   = (in_inject_en && in_inject_lane[g]) ? (in_write_data ^ in_inject_mask)
                                                             : in_write_data;

        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                rdata  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    rdata  <= mem[rd_ptr];
                end
                if (push_ok && !pop_ok) begin
                    cnt <= cnt + 1'b1;
                end else if (pop_ok && !push_ok) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end

        assign lane_rdata[g] = rdata;
        assign lane_cnt[g]   = cnt;
        assign lane_full[g]  = full;
        assign lane_empty[g] = empty;
    end

    logic [LANES-1:0] diff;

    always_comb begin
        diff = '0;
        for (int k = 1; k < LANES; k++) begin
            diff[k] = (lane_rdata[k] != lane_rdata[0]) || (lane_cnt[k] != lane_cnt[0]) ||
                      (lane_full[k] != lane_full[0]) || (lane_empty[k] != lane_empty[0]);
        end
    end

    // Fresh disagreement wins over a clear request in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_mismatch_lane <= '0;
        end else begin
            out_mismatch_lane <= diff | (out_mismatch_lane & {LANES{!in_clear_err}});
        end
    end

    assign out_mismatch  = |out_mismatch_lane;
    assign out_read_data = lane_rdata[0];
    assign out_count     = lane_cnt[0];
    assign out_is_full   = lane_full[0];
    assign out_is_empty  = lane_empty[0];

endmodule

// File: doc/lockstep_fifo.md
LOCKSTEP_FIFO -- requirements
Module: lockstep_fifo

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- WIDTH, 8, data bits per entry
- DEPTH, 8, entries per lane; power of two, >=2
- LANES, 2, redundant FIFO copies; 2..4
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_read_ctrl  in  1  pop request, broadcast to all lanes
- in_write_ctrl  in  1  push request, broadcast to all lanes
- in_write_data  in  WIDTH  push data
- in_inject_en  in  1  fault-injection enable, sampled with a push
- in_inject_lane  in  LANES  one bit per lane to corrupt
- in_inject_mask  in  WIDTH  XOR mask applied to corrupted lanes' push data
- in_clear_err  in  1  synchronous clear of the error flags
- out_read_data  out  WIDTH  lane 0 registered read data
- out_count  out  clog2(DEPTH)+1  lane 0 occupancy
- out_is_full  out  1  lane 0 full
- out_is_empty  out  1  lane 0 empty
- out_mismatch  out  1  sticky OR of out_mismatch_lane
- out_mismatch_lane  out  LANES  sticky per-lane disagreement vs lane 0; bit 0 always 0

Function
REQ-003 Every lane SHALL be an independent circular buffer with its own read pointer, write pointer and count, all driven by the same push/pop controls.
REQ-004 Push accepted iff in_write_ctrl && (!full || pop accepted in the same cycle); a push to a full lane without a pop SHALL be dropped with no state change.
REQ-005 Pop accepted iff in_read_ctrl && !empty; a pop on an empty lane SHALL be ignored. No write-to-read bypass: a simultaneous push and pop on an empty lane stores the word and leaves read data unchanged.
REQ-006 On an accepted pop, read data SHALL show the head entry on the next rising edge (1-cycle latency) and SHALL hold its value otherwise.
REQ-007 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL range 0..DEPTH; full = (count==DEPTH) and empty = (count==0); a simultaneous accepted push and pop SHALL leave count unchanged.
REQ-008 When in_inject_en=1 on an accepted push, lane k with in_inject_lane[k]=1 SHALL store in_write_data XOR in_inject_mask; all other lanes store in_write_data unmodified. in_inject_lane[0] SHALL be honoured identically.
REQ-009 Each cycle out of reset, for every lane k>=1, if its registered read data, count, full or empty differs from lane 0, out_mismatch_lane[k] SHALL set on the next edge and remain set.
REQ-010 in_clear_err=1 SHALL clear all mismatch bits on the next edge; a new mismatch detected in the same cycle SHALL take priority and leave its bit set.
REQ-011 out_mismatch SHALL be the combinational OR of out_mismatch_lane.

Reset
REQ-012 rst=1 SHALL immediately, without waiting for a clock edge, clear all pointers and counts, set out_read_data=0, out_count=0, out_is_empty=1, out_is_full=0, and clear out_mismatch_lane; storage contents need not be cleared.
REQ-013 No comparison SHALL occur while rst=1; reset asserted mid-operation SHALL discard all contents, and the first push after deassertion SHALL land at entry 0.

Verification
REQ-014 Fill/drain: push 0x01..0x08 with DEPTH=8 -> out_is_full=1 and out_count=8; a 9th push is dropped; eight pops return 0x01..0x08 in order, each one cycle after its pop; then out_is_empty=1.
REQ-015 Wrap: push 5, pop 5, push 6 values 0xA0..0xA5 -> pops return 0xA0..0xA5, out_mismatch stays 0.
REQ-016 Boundaries: push and pop together on a full FIFO -> count stays 8 and the new word is stored; push and pop together on an empty FIFO -> count=1 and out_read_data unchanged.
REQ-017 Injection: push 0x55 with in_inject_en=1, in_inject_lane=0b10, in_inject_mask=0x0F, then pop -> out_read_data=0x55, and out_mismatch_lane=0b10 one cycle after the read data diverges; in_clear_err clears it only after the corrupted word has been popped.
REQ-018 Async reset: assert rst between clock edges with 3 entries stored -> outputs take their reset values before the next edge; after release, push 0x77 and pop -> 0x77 is returned.
